// File: rtl/board_io_frontend.sv
// Board I/O front end: switch synchronisers, debouncers and edge pulses, a
// stretched SoC reset sequencer and a registered LED path. Optional LED PWM
// dimming is enabled by defining LED_PWM_EN.
module board_io_frontend #(
  parameter int N_SW        = 8,
  parameter int N_LED       = 8,
  parameter int DEB_CYCLES  = 500000,
  parameter int RST_STRETCH = 1024,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_SW-1:0]     sw_raw,
  input  logic [N_LED-1:0]    gpio_out,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_SW-1:0]     sw_db,
  output logic [N_SW-1:0]     sw_rise,
  output logic [N_SW-1:0]     sw_fall,
  output logic                soc_resetn,
  output logic [N_LED-1:0]    led
);

  localparam int DEB_W = (DEB_CYCLES + 1 > 2) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int RST_W = (RST_STRETCH + 1 > 2) ? $clog2(RST_STRETCH + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_STRETCH - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous switch pins
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0] sync_q1;
  logic [N_SW-1:0] sw_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= '0;
      sw_s    <= '0;
    end else begin
      sync_q1 <= sw_raw;
      sw_s    <= sync_q1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debouncer: a change is accepted after DEB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_SW; i++) begin : g_deb
    logic [DEB_W-1:0] deb_cnt;
    logic             db_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        deb_cnt <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sw_s[i] == db_q) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_cnt <= '0;
          db_q    <= sw_s[i];
          rise_q  <= sw_s[i];
          fall_q  <= ~sw_s[i];
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

    assign sw_db[i]   = db_q;
    assign sw_rise[i] = rise_q;
    assign sw_fall[i] = fall_q;
  end

  // ---------------------------------------------------------------------------
  // SoC reset sequencer. soc_resetn is registered alongside the state so it
  // always matches the state being entered.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_t;

  rst_state_t       rst_state;
  logic [RST_W-1:0] rst_cnt;
  logic             soc_resetn_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_state    <= ST_HOLD;
      rst_cnt      <= '0;
      soc_resetn_q <= 1'b0;
    end else begin
      case (rst_state)
        ST_HOLD: begin
          soc_resetn_q <= 1'b0;
          if (!sw_db[0]) begin
            rst_state <= ST_STRETCH;
            rst_cnt   <= '0;
          end
        end
        ST_STRETCH: begin
          rst_cnt <= rst_cnt + 1'b1;
          if (sw_db[0]) begin
            rst_state    <= ST_HOLD;
            soc_resetn_q <= 1'b0;
          end else if (rst_cnt == RST_LAST) begin
            rst_state    <= ST_RUN;
            soc_resetn_q <= 1'b1;
          end else begin
            soc_resetn_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (sw_db[0]) begin
            rst_state    <= ST_HOLD;
            soc_resetn_q <= 1'b0;
          end else begin
            soc_resetn_q <= 1'b1;
          end
        end
        default: begin
          rst_state    <= ST_HOLD;
          soc_resetn_q <= 1'b0;
        end
      endcase
    end
  end

  assign soc_resetn = soc_resetn_q;

  // ---------------------------------------------------------------------------
  // LED output register
  // ---------------------------------------------------------------------------
  logic [N_LED-1:0] led_q;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  assign pwm_on = (pwm_cnt < brightness);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_q   <= gpio_out & {N_LED{pwm_on}};
    end
  end
`else
  // Dimming is compiled out; brightness is intentionally left unconnected.
  logic unused_brightness;
  assign unused_brightness = ^brightness;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q <= '0;
    end else begin
      led_q <= gpio_out;
    end
  end
`endif

  assign led = led_q;

endmodule

// File: tb/tb_board_io_frontend.sv
// Self-checking bench for board_io_frontend: directed steps plus randomized
// switch/LED traffic against a history-based reference model.
module tb_board_io_frontend;

  localparam int N_SW        = 4;
  localparam int N_LED       = 4;
  localparam int DEB_CYCLES  = 4;
  localparam int RST_STRETCH = 8;
  localparam int PWM_BITS    = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic [N_SW-1:0]     sw_raw;
  logic [N_LED-1:0]    gpio_out;
  logic [PWM_BITS-1:0] brightness;
  logic [N_SW-1:0]     sw_db;
  logic [N_SW-1:0]     sw_rise;
  logic [N_SW-1:0]     sw_fall;
  logic                soc_resetn;
  logic [N_LED-1:0]    led;

  board_io_frontend #(
    .N_SW       (N_SW),
    .N_LED      (N_LED),
    .DEB_CYCLES (DEB_CYCLES),
    .RST_STRETCH(RST_STRETCH),
    .PWM_BITS   (PWM_BITS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sw_raw    (sw_raw),
    .gpio_out  (gpio_out),
    .brightness(brightness),
    .sw_db     (sw_db),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .soc_resetn(soc_resetn),
    .led       (led)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model: raw pins delayed two samples; a debounced level flips when
  // the last DEB_CYCLES synchronised samples all disagree with it; the SoC runs
  // once debounced switch 0 has read low for RST_STRETCH+1 consecutive samples.
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0]     m_s1, m_s2, m_db, m_rise, m_fall;
  logic                m_hist [N_SW][DEB_CYCLES];
  int                  m_zero_run;
  logic                m_soc;
  logic [N_LED-1:0]    m_led;
  logic [PWM_BITS-1:0] m_pwm;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < N_SW; c++)
      for (int k = 0; k < DEB_CYCLES; k++) m_hist[c][k] = 1'b0;
    m_zero_run = 0; m_soc = 1'b0; m_led = '0; m_pwm = '0;
  endtask

  task automatic model_edge();
    logic [N_SW-1:0] samp;
    logic [N_SW-1:0] db_old;
    logic            all_diff;
    samp   = m_s2;
    db_old = m_db;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N_SW; c++) begin
      for (int k = DEB_CYCLES - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = samp[c];
      all_diff = 1'b1;
      for (int k = 0; k < DEB_CYCLES; k++)
        if (m_hist[c][k] == db_old[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[c]   = ~db_old[c];
        m_rise[c] = ~db_old[c];
        m_fall[c] = db_old[c];
      end
    end
    if (db_old[0]) m_zero_run = 0;
    else if (m_zero_run < 100000) m_zero_run++;
    m_soc = (m_zero_run >= RST_STRETCH + 1);
`ifdef LED_PWM_EN
    m_led = (m_pwm < brightness) ? gpio_out : '0;
    m_pwm = m_pwm + 1'b1;
`else
    m_led = gpio_out;
`endif
    m_s2 = m_s1;
    m_s1 = sw_raw;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".sw_db"},      32'(sw_db),      32'(m_db));
    check({where, ".sw_rise"},    32'(sw_rise),    32'(m_rise));
    check({where, ".sw_fall"},    32'(sw_fall),    32'(m_fall));
    check({where, ".soc_resetn"}, 32'(soc_resetn), 32'(m_soc));
    check({where, ".led"},        32'(led),        32'(m_led));
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic step(input string where);
    @(posedge clk);
    if (resetn) model_edge();
    #1;
    check_all(where);
  endtask

  task automatic async_reset();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed steps followed by randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int n_rise, n_fall, n_on, n_zero;
    logic soc_seen;

    // Reset with every switch high: all outputs must sit at zero
    resetn = 1'b0; sw_raw = 4'hF; gpio_out = 4'hF; brightness = 4'hF;
    model_reset();
    #3;
    check("rst.sw_db", 32'(sw_db), 32'h0);
    check("rst.rise_fall", 32'({sw_rise, sw_fall}), 32'h0);
    check("rst.soc_resetn", 32'(soc_resetn), 32'h0);
    check("rst.led", 32'(led), 32'h0);
    step("rst_hold");
    step("rst_hold");

    // Release: STRETCH is entered on the first edge, RUN RST_STRETCH edges later
    sw_raw = '0; gpio_out = '0; resetn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step("release");
      if (soc_resetn === 1'b1) lat = i;
    end
    check("release.soc_latency", 32'(lat), 32'(RST_STRETCH + 1));

    // Clean rise on switch 2
    sw_raw[2] = 1'b1;
    lat = 0; n_rise = 0; n_fall = 0;
    for (int i = 1; i <= 12; i++) begin
      step("sw2_rise");
      if (sw_db[2] === 1'b1 && lat == 0) lat = i;
      if (sw_rise[2] === 1'b1) n_rise++;
      if (sw_fall[2] === 1'b1) n_fall++;
    end
    check("sw2.db_latency", 32'(lat), 32'(2 + DEB_CYCLES));
    check("sw2.rise_count", 32'(n_rise), 32'd1);
    check("sw2.fall_count", 32'(n_fall), 32'd0);

    // Glitch shorter than the debounce window on switch 1 is ignored
    sw_raw[1] = 1'b1;
    for (int i = 0; i < 3; i++) step("sw1_glitch");
    sw_raw[1] = 1'b0;
    n_rise = 0;
    for (int i = 0; i < 8; i++) begin
      step("sw1_glitch");
      if (sw_db[1] !== 1'b0 || sw_rise[1] !== 1'b0 || sw_fall[1] !== 1'b0) n_rise++;
    end
    check("sw1.glitch_activity", 32'(n_rise), 32'd0);
    sw_raw[1] = 1'b1;
    for (int i = 0; i < 8; i++) step("sw1_accept");
    check("sw1.accepted", 32'(sw_db[1]), 32'd1);

    // Switch 0 pressed while running: SoC reset asserts 2+DEB+1 edges later
    sw_raw[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      step("sw0_press");
      if (soc_resetn === 1'b0) lat = i;
    end
    check("sw0.press_latency", 32'(lat), 32'(2 + DEB_CYCLES + 1));

    // Released: debounce, one edge into STRETCH, then the stretch
    sw_raw[0] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      step("sw0_release");
      if (soc_resetn === 1'b1) lat = i;
    end
    check("sw0.release_latency", 32'(lat), 32'(2 + DEB_CYCLES + 1 + RST_STRETCH));

    // Bounce on switch 0 lands mid-STRETCH: back to HOLD, no high pulse
    sw_raw[0] = 1'b1;
    for (int i = 0; i < 10; i++) step("bounce_press");
    sw_raw[0] = 1'b0;
    for (int i = 0; i < 2 + DEB_CYCLES + 1; i++) step("bounce_drop");
    sw_raw[0] = 1'b1;
    soc_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step("bounce_high");
      if (soc_resetn !== 1'b0) soc_seen = 1'b1;
    end
    sw_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("bounce_low");
      if (soc_resetn !== 1'b0) soc_seen = 1'b1;
    end
    check("bounce.soc_pulse", 32'(soc_seen), 32'd0);
    for (int i = 0; i < 10; i++) step("bounce_settle");

    // LED path
    gpio_out = 4'hA; brightness = 4'd4;
    step("led_a");
`ifdef LED_PWM_EN
    n_on = 0; n_zero = 0;
    for (int i = 0; i < 16; i++) begin
      step("led_pwm4");
      if (led === 4'hA) n_on++;
      if (led === 4'h0) n_zero++;
    end
    check("pwm4.on_cycles", 32'(n_on), 32'd4);
    check("pwm4.off_cycles", 32'(n_zero), 32'd12);
    brightness = 4'd0;
    step("led_pwm0");
    n_zero = 0;
    for (int i = 0; i < 16; i++) begin
      step("led_pwm0");
      if (led === 4'h0) n_zero++;
    end
    check("pwm0.off_cycles", 32'(n_zero), 32'd16);
    brightness = 4'd4;
    for (int i = 0; i < 5; i++) step("led_pwm_mid");
`else
    check("led.follow_a", 32'(led), 32'hA);
    gpio_out = 4'h5;
    step("led_5");
    check("led.follow_5", 32'(led), 32'h5);
    n_on = 0; n_zero = 0;
`endif
    async_reset();
    check("midreset.led", 32'(led), 32'h0);
    check("midreset.soc_resetn", 32'(soc_resetn), 32'h0);
    check("midreset.sw_db", 32'(sw_db), 32'h0);
    check_all("midreset");
    step("midreset_hold");
    resetn = 1'b1;

    // Randomized traffic: slow-toggling switches, random LEDs and brightness
    for (int i = 0; i < 500; i++) begin
      step("random");
      for (int c = 0; c < N_SW; c++)
        if ($urandom_range(0, 7) == 0) sw_raw[c] = ~sw_raw[c];
      gpio_out = N_LED'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = PWM_BITS'($urandom);
      if (i == 250) begin
        async_reset();
        check_all("random_reset");
        step("random_reset_hold");
        resetn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
